// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, field positions and format codes.
// Used by the fetch stage and by control_unit so both agree on the instruction layout.
package cpu_pkg;

    localparam int INSTR_W  = 32;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int FMT_MSB  = 27;
    localparam int FMT_LSB  = 26;
    localparam int CTL_MSB  = 25;
    localparam int CTL_LSB  = 21;
    localparam int S_BIT    = 20;

    typedef enum logic [1:0] {
        FMT_ALU = 2'b00,
        FMT_LS  = 2'b01,
        FMT_BR  = 2'b10
    } fmt_e;

    function automatic logic [1:0] get_fmt(input logic [INSTR_W-1:0] instr);
        return instr[FMT_MSB:FMT_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is read directly from registered storage,
// so a word written in one cycle is first visible at the output in the next cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Storage, pointers and occupancy; write-on-full is legal when the head is read the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W + 1){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle instruction memory reads and buffered {pc, instr} delivery to decode.
// Optional macro FETCH_STALL_CNT_EN adds o_stall_cnt (stalled + bubble cycles, saturating).
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_req,
    output logic [ADDR_W-1:0]   o_imem_addr,
    input  logic [INSTR_W-1:0]  i_imem_rdata,
    output logic                o_dec_valid,
    input  logic                i_dec_ready,
    output logic [INSTR_W-1:0]  o_dec_instr,
    output logic [ADDR_W-1:0]   o_dec_pc,
    input  logic                i_redirect_valid,
    input  logic [ADDR_W-1:0]   i_redirect_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         o_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]      DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   PC_STEP = ADDR_W'(3'd4);

    logic [ADDR_W-1:0]          r_pc;
    logic [ADDR_W-1:0]          r_req_pc;
    logic                       r_inflight;

    logic [CNT_W-1:0]           w_count;
    logic [CNT_W:0]             w_used;
    logic [ADDR_W+INSTR_W-1:0]  w_head;
    logic                       w_dec_valid;
    logic                       w_deq;
    logic                       w_req;
    logic                       w_wr_en;
    logic                       w_unused_ok;

    // Credit check counts the word in flight and frees the slot being dequeued this cycle.
    always_comb begin
        w_dec_valid = (w_count != {CNT_W{1'b0}});
        w_deq       = w_dec_valid & i_dec_ready;
        w_used      = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_deq};
        w_req       = !i_rst && !i_redirect_valid && (w_used < DEPTH_L);
        w_wr_en     = r_inflight && !i_redirect_valid;
    end

    // PC and in-flight tracking; a redirect drops the response returning this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= {ADDR_W{1'b0}};
            r_inflight <= 1'b0;
        end else if (i_redirect_valid) begin
            r_pc       <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_redirect_valid),
        .i_wr_en   (w_wr_en),
        .i_wr_data ({r_req_pc, i_imem_rdata}),
        .i_rd_en   (w_deq),
        .o_rd_data (w_head),
        .o_count   (w_count)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_dec_valid = w_dec_valid;
    assign o_dec_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign o_dec_instr = w_head[INSTR_W-1:0];

    // Redirect targets are word aligned; the low address bits are intentionally ignored.
    assign w_unused_ok = &{1'b0, i_redirect_pc[1:0]};

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles decode is held off or starved, saturating at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((!w_dec_valid || !i_dec_ready) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: phased random stimulus against a queue-based model.
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .o_dec_valid      (dec_valid),
        .i_dec_ready      (dec_ready),
        .o_dec_instr      (dec_instr),
        .o_dec_pc         (dec_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .o_stall_cnt      (stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        int          cycles;
        int          rst_pct;
        int          ready_pct;
        int          redir_pct;
        bit          fixed_rpc;
        logic [31:0] rpc;
    } phase_t;

    phase_t phases [12];

    // Reference model: program-order queue of buffered pcs plus one in-flight read.
    logic [31:0] q_pc [$];
    logic [31:0] m_pc;
    logic [31:0] m_inf_pc;
    logic [31:0] m_stall;
    bit          m_inf;
    bit          m_init;
    bit          m_clean;
    bit          last_req;
    logic [31:0] last_addr;
    bit          exp_valid;
    bit          exp_deq;
    bit          exp_req;
    int          stall_reqs;

    initial begin
        phases = '{
            '{3,   100, 100, 0, 1'b0, 32'h0},            // reset
            '{20,  0,   100, 0, 1'b0, 32'h0},            // streaming across address wrap
            '{2,   100, 0,   0, 1'b0, 32'h0},            // reset again
            '{10,  0,   0,   0, 1'b0, 32'h0},            // decode stalled after reset
            '{12,  0,   100, 0, 1'b0, 32'h0},            // drain in order
            '{3,   0,   0,   0, 1'b0, 32'h0},            // fill buffer
            '{1,   0,   0,   100, 1'b1, 32'h0000_0103},  // redirect with full buffer
            '{10,  0,   100, 0, 1'b0, 32'h0},
            '{600, 1,   70,  5, 1'b0, 32'h0},
            '{400, 2,   30,  8, 1'b0, 32'h0},
            '{3,   100, 50,  0, 1'b0, 32'h0},
            '{10,  0,   50,  0, 1'b0, 32'h0}
        };
        rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        m_pc = 32'h0; m_inf_pc = 32'h0; m_stall = 32'h0;
        m_inf = 1'b0; m_init = 1'b0; m_clean = 1'b0;
        last_req = 1'b0; last_addr = 32'h0; stall_reqs = 0;

        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                @(negedge clk);
                rst            = ($urandom_range(99) < phases[p].rst_pct);
                dec_ready      = ($urandom_range(99) < phases[p].ready_pct);
                redirect_valid = ($urandom_range(99) < phases[p].redir_pct);
                redirect_pc    = phases[p].fixed_rpc ? phases[p].rpc : $urandom;
                imem_rdata     = last_req ? mem_word(last_addr) : $urandom;
                #1;

                exp_valid = (q_pc.size() != 0);
                exp_deq   = exp_valid && dec_ready;
                exp_req   = !rst && !redirect_valid &&
                            ((q_pc.size() + int'(m_inf) - int'(exp_deq)) < DEPTH);

                check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
                if (m_init) begin
                    check_eq("imem_addr", imem_addr, m_pc);
                    check_eq("dec_valid", {31'd0, dec_valid}, {31'd0, exp_valid});
`ifdef FETCH_STALL_CNT_EN
                    check_eq("stall_cnt", stall_cnt, m_stall);
`endif
                end
                if (m_init && exp_valid) begin
                    check_eq("dec_pc", dec_pc, q_pc[0]);
                    check_eq("dec_instr", dec_instr, mem_word(q_pc[0]));
                end
                if (m_init && m_clean) begin
                    check_eq("dec_pc_rst", dec_pc, 32'h0);
                    check_eq("dec_instr_rst", dec_instr, 32'h0);
                end
                if (p == 3 && imem_req) begin
                    stall_reqs++;
                end
                if (p == 3 && c == phases[p].cycles - 1) begin
                    check_eq("stall_reqs", stall_reqs, DEPTH);
                end

                // Advance the model across the coming clock edge.
                last_req  = exp_req;
                last_addr = m_pc;
                if (rst) begin
                    q_pc.delete();
                    m_pc    = RST_PC;
                    m_inf   = 1'b0;
                    m_init  = 1'b1;
                    m_clean = 1'b1;
                    m_stall = 32'h0;
                end else begin
                    if ((!exp_valid || !dec_ready) && m_stall != 32'hFFFF_FFFF) begin
                        m_stall = m_stall + 32'd1;
                    end
                    if (exp_deq) begin
                        void'(q_pc.pop_front());
                    end
                    if (redirect_valid) begin
                        q_pc.delete();
                        m_inf = 1'b0;
                        m_pc  = {redirect_pc[31:2], 2'b00};
                    end else begin
                        if (m_inf) begin
                            q_pc.push_back(m_inf_pc);
                            m_clean = 1'b0;
                        end
                        m_inf = exp_req;
                        if (exp_req) begin
                            m_inf_pc = m_pc;
                            m_pc     = m_pc + 32'd4;
                        end
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
